// File: rtl/knn_pkg.sv
// Shared types and helpers for the k-NN majority vote stage.
// Holds the FSM state encoding and the vote-counter width function.
package knn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SELECT = 2'd2
  } state_e;

  function automatic int vote_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/knn_vote_if.sv
// Handshake and data bundle between knn_system and knn_vote.
// The master drives the sorted arrays, and the slave returns the class.
interface knn_vote_if #(
  parameter int W = 8,
  parameter int L = 8,
  parameter int K = 3
);
  import knn_pkg::*;

  localparam int CW = vote_w(K);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  distance_array_sorted [L];
  logic [W-1:0]  type_array_sorted     [L];
  logic          out_valid;
  logic [W-1:0]  class_out;
  logic [CW-1:0] max_votes;
  logic [W-1:0]  nearest_dist;

  modport master (
    output in_valid, distance_array_sorted,
    output type_array_sorted,
    input  in_ready, out_valid, class_out,
    input  max_votes, nearest_dist
  );

  modport slave (
    input  in_valid, distance_array_sorted,
    input  type_array_sorted,
    output in_ready, out_valid, class_out,
    output max_votes, nearest_dist
  );

endinterface

// File: rtl/knn_vote_bank.sv
// Bank of C vote counters with a single increment port and a single read port.
// A counter stops at K, which is the most votes that one set can cast.
module knn_vote_bank #(
  parameter int C  = 4,
  parameter int K  = 3,
  parameter int CW = 2,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc_en,
  input  logic [IW-1:0] inc_class,
  input  logic [IW-1:0] rd_cls,
  output logic [CW-1:0] rd_cnt
);

  logic [CW-1:0] r_cnt [C];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < C; i++)
        r_cnt[i] <= '0;
    end else if (inc_en &&
                 r_cnt[inc_class] != CW'(K)) begin
      r_cnt[inc_class] <= r_cnt[inc_class] + 1'b1;
    end
  end

  assign rd_cnt = r_cnt[rd_cls];

endmodule

// File: rtl/knn_vote.sv
// Majority-vote classifier: it captures the sorted arrays and counts K votes.
// It then scans the C counters for the argmax and presents one result strobe.
module knn_vote
  import knn_pkg::*;
#(
  parameter int W = 8,
  parameter int L = 8,
  parameter int K = 3,
  parameter int C = 4
) (
  input logic       clk,
  input logic       rst,
  knn_vote_if.slave bus
);

  localparam int CW = vote_w(K);
  localparam int IW = (C > 1) ? $clog2(C) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  state_e        r_state;
  logic [W-1:0]  r_type [K];
  logic [KW-1:0] r_idx;
  logic [IW-1:0] r_cls;
  logic [IW-1:0] r_best_cls;
  logic [CW-1:0] r_best_cnt;
  logic          r_out_valid;
  logic [W-1:0]  r_class;
  logic [CW-1:0] r_votes;
  logic [W-1:0]  r_near;

  logic          w_accept;
  logic          w_inc_en;
  logic          w_better;
  logic          w_last_idx;
  logic          w_last_cls;
  logic [W-1:0]  w_type;
  logic [CW-1:0] w_cnt;
  logic          w_unused;

  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_type     = r_type[r_idx];
  assign w_inc_en   = (r_state == COUNT) && (int'(w_type) < C);
  assign w_better   = w_cnt > r_best_cnt;
  assign w_last_idx = r_idx == KW'(K - 1);
  assign w_last_cls = r_cls == IW'(C - 1);

  knn_vote_bank #(
    .C (C),
    .K (K),
    .CW(CW),
    .IW(IW)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_accept),
    .inc_en   (w_inc_en),
    .inc_class(w_type[IW-1:0]),
    .rd_cls   (r_cls),
    .rd_cnt   (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_cls       <= '0;
      r_best_cls  <= '0;
      r_best_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_class     <= '0;
      r_votes     <= '0;
      r_near      <= '0;
      for (int i = 0; i < K; i++)
        r_type[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < K; i++)
              r_type[i] <= bus.type_array_sorted[i];
            r_near  <= bus.distance_array_sorted[0];
            r_idx   <= '0;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          r_idx <= r_idx + 1'b1;
          if (w_last_idx) begin
            r_idx      <= '0;
            r_cls      <= '0;
            r_best_cls <= '0;
            r_best_cnt <= '0;
            r_state    <= SELECT;
          end
        end
        SELECT: begin
          if (w_better) begin
            r_best_cls <= r_cls;
            r_best_cnt <= w_cnt;
          end
          r_cls <= r_cls + 1'b1;
          // The last class is folded into the result on the same edge.
          if (w_last_cls) begin
            r_class     <= W'(w_better ? r_cls : r_best_cls);
            r_votes     <= w_better ? w_cnt : r_best_cnt;
            r_out_valid <= 1'b1;
            r_cls       <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_unused = 1'b0;
    for (int i = 1; i < L; i++)
      w_unused = w_unused ^ (^bus.distance_array_sorted[i]);
    for (int i = K; i < L; i++)
      w_unused = w_unused ^ (^bus.type_array_sorted[i]);
  end

  assign bus.in_ready     = (r_state == IDLE);
  assign bus.out_valid    = r_out_valid;
  assign bus.class_out    = r_class;
  assign bus.max_votes    = r_votes;
  assign bus.nearest_dist = r_near;

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote with three parameter sets sharing clk/rst.
// It covers majority, tie, invalid types, back-to-back, reset abort and K=L.
module tb_knn_vote;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  knn_vote_if #(.W(8), .L(8), .K(3)) b0();
  knn_vote_if #(.W(8), .L(8), .K(2)) b1();
  knn_vote_if #(.W(8), .L(8), .K(8)) b2();

  knn_vote #(.W(8), .L(8), .K(3), .C(4)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  knn_vote #(.W(8), .L(8), .K(2), .C(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  knn_vote #(.W(8), .L(8), .K(8), .C(1)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  logic ov  [3];
  logic rdy [3];
  int   cls [3];
  int   mv  [3];
  int   nd  [3];

  assign ov[0]  = b0.out_valid;
  assign ov[1]  = b1.out_valid;
  assign ov[2]  = b2.out_valid;
  assign rdy[0] = b0.in_ready;
  assign rdy[1] = b1.in_ready;
  assign rdy[2] = b2.in_ready;
  assign cls[0] = int'(b0.class_out);
  assign cls[1] = int'(b1.class_out);
  assign cls[2] = int'(b2.class_out);
  assign mv[0]  = int'(b0.max_votes);
  assign mv[1]  = int'(b1.max_votes);
  assign mv[2]  = int'(b2.max_votes);
  assign nd[0]  = int'(b0.nearest_dist);
  assign nd[1]  = int'(b1.nearest_dist);
  assign nd[2]  = int'(b2.nearest_dist);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input int u, input int t[8],
                       input int d0, input logic v);
    for (int i = 0; i < 8; i++) begin
      case (u)
        0: begin
          b0.type_array_sorted[i]     = 8'(t[i]);
          b0.distance_array_sorted[i] = 8'(d0 + 2 * i);
        end
        1: begin
          b1.type_array_sorted[i]     = 8'(t[i]);
          b1.distance_array_sorted[i] = 8'(d0 + 2 * i);
        end
        default: begin
          b2.type_array_sorted[i]     = 8'(t[i]);
          b2.distance_array_sorted[i] = 8'(d0 + 2 * i);
        end
      endcase
    end
    case (u)
      0:       b0.in_valid = v;
      1:       b1.in_valid = v;
      default: b2.in_valid = v;
    endcase
  endtask

  // One transaction: lat counts edges from the capture edge to the strobe.
  task automatic run(input string tag, input int u, input int t[8],
                     input int d0, input int ec, input int ev,
                     input int en, input int elat);
    int lat;
    @(negedge clk);
    drive(u, t, d0, 1'b1);
    @(negedge clk);
    drive(u, t, d0, 1'b0);
    check({tag, ".busy"}, int'(rdy[u]), 0);
    lat = 1;
    while (!ov[u] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, lat, elat);
    check({tag, ".cls"}, cls[u], ec);
    check({tag, ".votes"}, mv[u], ev);
    check({tag, ".near"}, nd[u], en);
    @(negedge clk);
    check({tag, ".pulse"}, int'(ov[u]), 0);
    check({tag, ".ready"}, int'(rdy[u]), 1);
  endtask

  int sets_t [3][8];
  int sets_d [3];
  int exp_c  [3];
  int exp_v  [3];
  int exp_s  [3];
  int nres;
  int seen;

  initial begin
    sets_t = '{'{1, 1, 0, 0, 0, 0, 0, 0},
               '{0, 3, 3, 0, 0, 0, 0, 0},
               '{2, 2, 2, 0, 0, 0, 0, 0}};
    sets_d = '{3, 4, 6};
    exp_c  = '{1, 3, 2};
    exp_v  = '{2, 2, 3};
    exp_s  = '{0, 2, 1};

    rst = 1'b1;
    drive(0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0);
    drive(1, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0);
    drive(2, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.ready", int'(rdy[0]), 1);
    check("rst.ov", int'(ov[0]), 0);
    check("rst.cls", cls[0], 0);
    check("rst.votes", mv[0], 0);
    check("rst.near", nd[0], 0);

    run("maj", 0, '{2, 1, 2, 0, 0, 0, 0, 0}, 5, 2, 2, 5, 8);
    repeat (3) @(negedge clk);
    check("hold.cls", cls[0], 2);
    check("hold.near", nd[0], 5);

    run("oor1", 0, '{9, 7, 3, 0, 0, 0, 0, 0}, 11, 3, 1, 11, 8);
    run("oor2", 0, '{9, 7, 5, 0, 0, 0, 0, 0}, 12, 0, 0, 12, 8);

    // Inputs change every cycle; only sets present at accept edges count.
    nres = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (ov[0]) begin
        if (nres < 3) begin
          check("b2b.at", c, 8 * (nres + 1));
          check("b2b.cls", cls[0], exp_c[exp_s[nres]]);
          check("b2b.votes", mv[0], exp_v[exp_s[nres]]);
          check("b2b.near", nd[0], sets_d[exp_s[nres]]);
        end
        nres++;
      end
      if (c < 24) drive(0, sets_t[c % 3], sets_d[c % 3], 1'b1);
      else b0.in_valid = 1'b0;
    end
    check("b2b.count", nres, 3);

    @(negedge clk);
    drive(0, '{1, 2, 3, 0, 0, 0, 0, 0}, 9, 1'b1);
    @(negedge clk);
    b0.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.ov", int'(ov[0]), 0);
    check("abort.cls", cls[0], 0);
    check("abort.votes", mv[0], 0);
    check("abort.near", nd[0], 0);
    check("abort.ready", int'(rdy[0]), 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0]) seen = 1;
    end
    check("abort.noov", seen, 0);
    run("post", 0, '{0, 0, 1, 0, 0, 0, 0, 0}, 2, 0, 2, 2, 8);

    run("tie", 1, '{3, 1, 0, 0, 0, 0, 0, 0}, 20, 1, 1, 20, 7);
    run("edge", 2, '{0, 0, 0, 0, 0, 0, 0, 0}, 1, 0, 8, 1, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/knn_vote.md
# knn_vote

Majority-vote classifier stage that sits directly downstream of `knn_system`. It captures one set of sorted distance/type arrays, counts class votes over the K nearest entries one entry per cycle, and then scans the vote counters to select the winning class. It presents the class with a one-cycle valid pulse. Vote counting and class selection are sequential, so area stays independent of L.

## Interface
- `W`, 8: word width of distances, types and `class_out`
- `L`, 8: number of entries in the sorted input arrays
- `K`, 3: neighbours that vote; legal range is 1 ≤ K ≤ L
- `C`, 4: number of classes; legal range is 1 ≤ C ≤ 2^W; valid types are 0..C-1
- `CW`, $clog2(K+1): vote-counter width (derived, not overridable)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `in_valid` in 1: sorted arrays are valid this cycle
- `in_ready` out 1: block can accept arrays (IDLE)
- `distance_array_sorted[0:L-1]` in W each: ascending distances
- `type_array_sorted[0:L-1]` in W each: class of each entry
- `out_valid` out 1: one-cycle result strobe
- `class_out` out W: winning class
- `max_votes` out CW: vote count of winning class
- `nearest_dist` out W: `distance_array_sorted[0]` of the accepted set

## Operation
- States:
  - `IDLE`: `in_ready`=1
  - `COUNT`: `idx` runs 0..K-1
  - `SELECT`: `cls` runs 0..C-1
- Accept:
  - In `IDLE` with `in_valid`=1 on an edge, register entries 0..K-1 of both arrays.
  - Register `nearest_dist`.
  - Clear all C counters; `idx`←0; go to `COUNT`.
- `COUNT`:
  - Each edge, if `type[idx]` < C, increment `counter[type[idx]]`. Out-of-range types are ignored.
  - On `idx`=K-1, go to `SELECT` with `cls`←0, `best_cls`←0, `best_cnt`←0.
- `SELECT`:
  - Each edge, if `counter[cls]` > `best_cnt`, update `best_cls`/`best_cnt`. The comparison is strict, so ties go to the lowest class index.
  - On `cls`=C-1, register `class_out`/`max_votes` from the final comparison, pulse `out_valid`, go to `IDLE`.
- If no entry has a valid type, the result is `class_out`=0 and `max_votes`=0.
- `in_valid` outside `IDLE` is ignored. Accepted inputs are never overwritten mid-operation.
- Counters saturate at K and cannot overflow, given the CW definition.
- `class_out`, `max_votes` and `nearest_dist` hold their values until the next result.

## Timing
- Reset values:
  - state `IDLE`, `in_ready`=1
  - `out_valid`=0, `class_out`=0, `max_votes`=0, `nearest_dist`=0
  - all counters and indices 0
- Latency:
  - Capture edge is t0; `out_valid` is high in the cycle following edge t0+K+C.
  - Total is K+C+1 edges from capture to strobe (K COUNT edges, C SELECT edges, including the capture edge).
- `in_ready` falls the cycle after capture and rises in the same cycle `out_valid` is high.
  - A new `in_valid` in the `out_valid` cycle is accepted (back-to-back).
  - Throughput is one classification per K+C+1 cycles.
- `rst` mid-`COUNT` or mid-`SELECT` aborts the operation: no `out_valid`, outputs cleared, `IDLE` on the next cycle.
- `rst` takes priority over a simultaneous `in_valid`.

## Structure
- Shared package `knn_pkg`: state enum (`IDLE`, `COUNT`, `SELECT`) and the vote-width helper function.
- One sub-module `knn_vote_bank` holds the C counters. Its inputs are `clear`, `inc_en` and `inc_class`; it exposes a read port selected by `cls`.
- The FSM, index counters and the argmax register stay in `knn_vote`.

## Test plan
- Majority win: K=3, C=4, types [2,1,2,0,…], distances [5,7,9,…].
  - Expect `class_out`=2, `max_votes`=2, `nearest_dist`=5.
  - `out_valid` is a single cycle, K+C+1 edges (8) after capture.
- Tie: K=2, types [3,1,…].
  - Expect `class_out`=1, `max_votes`=1 (lowest index wins).
- Out-of-range types: C=4, K=3, types [9,7,3].
  - Expect `class_out`=3, `max_votes`=1.
  - With types [9,7,5], expect `class_out`=0, `max_votes`=0.
- Busy drop and back-to-back:
  - Hold `in_valid` high continuously with alternating array sets.
  - Expect results only for sets present at accept edges, with `out_valid` spacing exactly 8 cycles.
- Reset mid-operation:
  - Assert `rst` for one cycle at capture+2.
  - Expect no `out_valid` and all outputs 0; `in_ready`=1 on the next cycle.
  - The next transaction completes normally.
- Edge parameters: K=L=8, C=1, all types 0.
  - Expect `class_out`=0, `max_votes`=8, latency 10.
